// File: rtl/mac_accel.sv
// Multiply-accumulate engine: takes N_TERMS operand pairs and produces their
// sum of products through a two-stage pipeline (multiply, then accumulate).
//
// state | meaning
// IDLE  | waiting for start; result and ovf hold the last operation's values
// RUN   | accepting operand pairs, in_ready high
// DRAIN | last product is still in flight through the accumulate stage
// DONE  | result updated, done pulses for this one cycle
module mac_accel #(
  parameter int DATA_W  = 4,
  parameter int ACC_W   = 12,
  parameter int N_TERMS = 10,
  parameter int SAT     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_mode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  result,
  output logic              done,
  output logic              busy,
  output logic              ovf
);

  localparam int PW = 2 * DATA_W;
  localparam int XP = ACC_W + 1 - PW;
  localparam logic [7:0] LAST_IDX = 8'(N_TERMS - 1);

  generate
    if (ACC_W < PW) begin : g_bad_acc_w
      $error("mac_accel: ACC_W must be at least 2*DATA_W");
    end
    if (N_TERMS < 1 || N_TERMS > 255) begin : g_bad_n_terms
      $error("mac_accel: N_TERMS must be in 1..255");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [7:0]      count;
  logic            mode_signed;
  logic [PW-1:0]   prod_q;
  logic            prod_vld;
  logic [ACC_W-1:0] acc;

  logic            accept;
  logic [PW-1:0]   ext_a;
  logic [PW-1:0]   ext_b;
  logic [PW-1:0]   prod;
  logic [ACC_W:0]  acc_x;
  logic [ACC_W:0]  prod_x;
  logic [ACC_W:0]  sum;
  logic            add_ovf;
  logic [ACC_W-1:0] acc_add;

  assign accept   = (state == RUN) && in_valid;
  assign in_ready = (state == RUN);
  assign busy     = (state != IDLE);

  // Sign-extending both operands lets one unsigned multiplier serve both
  // modes: the low PW bits are the correct two's-complement product.
  always_comb begin
    ext_a = mode_signed ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
    ext_b = mode_signed ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
    prod  = ext_a * ext_b;
  end

  // One guard bit above the accumulator exposes the true sum of this add.
  always_comb begin
    prod_x  = mode_signed ? {{XP{prod_q[PW-1]}}, prod_q} : {{XP{1'b0}}, prod_q};
    acc_x   = mode_signed ? {acc[ACC_W-1], acc} : {1'b0, acc};
    sum     = acc_x + prod_x;
    add_ovf = mode_signed ? (sum[ACC_W] != sum[ACC_W-1]) : sum[ACC_W];
    acc_add = sum[ACC_W-1:0];
    if (SAT != 0 && add_ovf) begin
      if (!mode_signed) begin
        acc_add = '1;
      end else if (sum[ACC_W]) begin
        acc_add = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        acc_add = {1'b0, {(ACC_W-1){1'b1}}};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      mode_signed <= 1'b0;
      prod_q      <= '0;
      prod_vld    <= 1'b0;
      acc         <= '0;
      result      <= '0;
      done        <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      done     <= 1'b0;
      prod_vld <= accept;
      if (accept) begin
        prod_q <= prod;
      end
      if (prod_vld) begin
        acc <= acc_add;
        if (add_ovf) begin
          ovf <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            acc         <= '0;
            count       <= '0;
            ovf         <= 1'b0;
            mode_signed <= signed_mode;
          end
        end
        RUN: begin
          if (accept) begin
            count <= count + 8'd1;
            if (count == LAST_IDX) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // The final product lands in acc on this same edge, so result
          // takes the post-add value directly.
          state  <= DONE;
          result <= prod_vld ? acc_add : acc;
          done   <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accel.sv
// Bench for mac_accel: three configurations share one stimulus stream and are
// compared against a sum-of-products reference computed with plain integers.
module tb_mac_accel;

  localparam int N = 10;

  logic clk;
  logic rst;
  logic start;
  logic signed_mode;
  logic [3:0] a;
  logic [3:0] b;
  logic in_valid;

  logic        rdy0, rdy1, rdy2;
  logic [11:0] res0;
  logic [7:0]  res1, res2;
  logic        done0, done1, done2;
  logic        busy0, busy1, busy2;
  logic        ovf0, ovf1, ovf2;

  int n_checks;
  int n_pass;

  int a_q[N];
  int b_q[N];
  longint er[3];
  bit     eo[3];
  int     cfg_w[3] = '{12, 8, 8};
  bit     cfg_s[3] = '{1'b0, 1'b0, 1'b1};

  mac_accel #(.DATA_W(4), .ACC_W(12), .N_TERMS(N), .SAT(0)) u_def (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .in_valid(in_valid), .in_ready(rdy0),
    .result(res0), .done(done0), .busy(busy0), .ovf(ovf0)
  );

  mac_accel #(.DATA_W(4), .ACC_W(8), .N_TERMS(N), .SAT(0)) u_wrap8 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .in_valid(in_valid), .in_ready(rdy1),
    .result(res1), .done(done1), .busy(busy1), .ovf(ovf1)
  );

  mac_accel #(.DATA_W(4), .ACC_W(8), .N_TERMS(N), .SAT(1)) u_sat8 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .in_valid(in_valid), .in_ready(rdy2),
    .result(res2), .done(done2), .busy(busy2), .ovf(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint opval(input int x, input bit sgn);
    return (sgn && x >= 8) ? longint'(x - 16) : longint'(x);
  endfunction

  // Expected result and overflow for one accumulator width / mode.
  function automatic void model(input int acc_w, input bit sat, input bit sgn,
                                output longint res, output bit ov);
    longint lo, hi, acc;
    lo  = sgn ? -(longint'(1) << (acc_w - 1)) : 0;
    hi  = sgn ? (longint'(1) << (acc_w - 1)) - 1 : (longint'(1) << acc_w) - 1;
    acc = 0;
    ov  = 1'b0;
    for (int i = 0; i < N; i++) begin
      acc += opval(a_q[i], sgn) * opval(b_q[i], sgn);
      if (acc > hi || acc < lo) begin
        ov = 1'b1;
        if (sat) acc = (acc > hi) ? hi : lo;
      end
    end
    res = acc & ((longint'(1) << acc_w) - 1);
  endfunction

  task automatic fill_const(input int va, input int vb);
    for (int i = 0; i < N; i++) begin
      a_q[i] = va;
      b_q[i] = vb;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++) begin
      a_q[i] = int'($urandom_range(0, 15));
      b_q[i] = int'($urandom_range(0, 15));
    end
  endtask

  task automatic check_results(input string tag);
    check({tag, "_res12"}, res0, er[0]);
    check({tag, "_res8w"}, res1, er[1]);
    check({tag, "_res8s"}, res2, er[2]);
    check({tag, "_ovf"}, {ovf0, ovf1, ovf2}, {eo[0], eo[1], eo[2]});
  endtask

  // gaps: 0 back-to-back, 1 alternate cycles, 2 random.
  // abort_at > 0 asserts rst right after that many accepts.
  task automatic run_op(input string tag, input bit sgn, input int gaps,
                        input bit poke, input int abort_at);
    int idx;
    int guard;
    idx   = 0;
    guard = 0;
    for (int k = 0; k < 3; k++) model(cfg_w[k], k == 2, sgn, er[k], eo[k]);

    @(posedge clk); #1;
    start = 1'b1; signed_mode = sgn; in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; signed_mode = ~sgn;

    while (idx < N && guard < 200) begin
      if (gaps == 1)      in_valid = (guard % 2 == 0);
      else if (gaps == 2) in_valid = ($urandom_range(0, 2) != 0);
      else                in_valid = 1'b1;
      if (in_valid) begin
        a = 4'(a_q[idx]);
        b = 4'(b_q[idx]);
      end else begin
        a = 4'($urandom);
        b = 4'($urandom);
      end
      start = poke && (idx == 3);
      signed_mode = 1'($urandom);
      @(negedge clk);
      check({tag, "_run_ready"}, {rdy0, rdy1, rdy2, busy0, done0}, 5'b11110);
      if (guard == 0) check({tag, "_ovf_clr"}, {ovf0, ovf1, ovf2}, 0);
      @(posedge clk);
      if (in_valid) idx++;
      if (abort_at > 0 && idx == abort_at) begin
        #1;
        rst = 1'b1; in_valid = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check({tag, "_abort_ctl"}, {rdy0, busy0, done0, busy1, done1, busy2, done2}, 0);
        check({tag, "_abort_res"}, {res0, res1, res2}, 0);
        check({tag, "_abort_ovf"}, {ovf0, ovf1, ovf2}, 0);
        return;
      end
      #1;
      guard++;
    end
    if (idx < N) check({tag, "_accept_budget"}, idx, N);

    // Extra valid data and start pokes here must be ignored.
    in_valid = 1'b1; a = 4'($urandom); b = 4'($urandom);
    start = poke; signed_mode = 1'($urandom);
    @(negedge clk);
    check({tag, "_drain"}, {rdy0, rdy1, rdy2, busy0, busy1, busy2, done0, done1, done2},
          9'b000111000);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check({tag, "_done"}, {rdy0, busy0, done0, done1, done2}, 5'b01111);
    check_results({tag, "_done"});
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, {rdy0, busy0, busy1, busy2, done0, done1, done2}, 0);
    check_results({tag, "_idle"});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1; start = 1'b1; signed_mode = 1'b0;
    a = '0; b = '0; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("reset_ctl", {rdy0, busy0, done0, ovf0, rdy2, busy2, done2, ovf2}, 0);
    check("reset_res", {res0, res1, res2}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    fill_const(3, 5);
    run_op("u3x5", 1'b0, 0, 1'b0, 0);
    check("u3x5_lit", res0, 12'h096);

    fill_const(14, 3);
    run_op("s_gap", 1'b1, 1, 1'b0, 0);
    check("s_gap_lit", res0, 12'hFC4);

    fill_const(15, 15);
    run_op("u15x15", 1'b0, 0, 1'b0, 0);
    check("u15x15_lit", {res1, ovf1, res2, ovf2}, {8'hCA, 1'b1, 8'hFF, 1'b1});

    fill_const(1, 2);
    run_op("poke", 1'b0, 2, 1'b1, 0);
    fill_rand();
    run_op("poke_rs", 1'b1, 2, 1'b1, 0);

    fill_const(7, 9);
    run_op("abort", 1'b0, 0, 1'b0, 5);
    fill_const(2, 3);
    run_op("after_abort", 1'b0, 0, 1'b0, 0);

    for (int t = 0; t < 12; t++) begin
      fill_rand();
      run_op($sformatf("rand%0d", t), 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
